// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller / memory-port arbiter slice.
//   arb_state_e     : state encoding of the shared-port arbiter
//   REG_ADDR_W_DEF  : default register-index width
//   TURNAROUND_MAX  : largest supported bus turnaround (idle cycles)
//   GAP_CNT_W       : width of the turnaround gap counter
package hazard_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_D    = 2'd2,
        ARB_GAP  = 2'd3
    } arb_state_e;

    localparam int unsigned REG_ADDR_W_DEF = 2;
    localparam int unsigned TURNAROUND_MAX = 3;
    localparam int unsigned GAP_CNT_W      = 2;

endpackage

// File: rtl/mem_port_arb.sv
// Sequential arbiter for the single shared memory port (instruction fetch vs
// data access), with a programmable idle gap after every finished access.
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset
//   d_req_mem      MEM stage needs the port (wins over fetch in IDLE)
//   fetch_want     IF stage wants to fetch
//   abort          in-flight fetch abandoned by a control miss
//   mem_ready      current access completes this cycle
//   state_o        current arbiter state
module mem_port_arb
    import hazard_pkg::*;
#(
    parameter int unsigned TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       d_req_mem,
    input  logic       fetch_want,
    input  logic       abort,
    input  logic       mem_ready,
    output arb_state_e state_o
);

    localparam logic                 GAP_EN   = (TURNAROUND != 0);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (TURNAROUND == 0) ? '0
                                              : GAP_CNT_W'(TURNAROUND - 1);

    arb_state_e           state_q, state_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ARB_IDLE: begin
                if (d_req_mem) begin
                    state_d = ARB_D;
                end else if (fetch_want) begin
                    state_d = ARB_IF;
                end
            end
            ARB_IF: begin
                // A fetch is never pre-empted by a data request; only a
                // completion or a redirect ends it.
                if (mem_ready || abort) begin
                    state_d = GAP_EN ? ARB_GAP : ARB_IDLE;
                    gap_d   = GAP_LOAD;
                end
            end
            ARB_D: begin
                if (mem_ready) begin
                    state_d = GAP_EN ? ARB_GAP : ARB_IDLE;
                    gap_d   = GAP_LOAD;
                end
            end
            ARB_GAP: begin
                if (gap_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/hazard_ctrl_arb.sv
// Pipeline hazard unit for the 5-stage core plus shared memory port arbiter.
// Generates ID data-hazard stalls, branch-miss flushes, MEM/IF memory stalls
// and the port grants for instruction fetch and data access.
// Ports:
//   clk, reset_n                       clock / asynchronous active-low reset
//   rs_id, rt_id, use_rs, use_rt       ID source registers and their use
//   use_rs_at_id                       ID consumes rs in ID (register jumps)
//   reg_write_{ex,mem,wb}              stage writes the register file
//   write_reg_{ex,mem,wb}              destination register of that stage
//   d_mem_read_ex                      load in EX
//   d_req_mem                          load/store in MEM needs the port
//   jump_miss, cond_branch_miss        mispredictions resolved this cycle
//   mem_ready                          shared port access completes
//   i_mem_read, d_mem_grant            port ownership this cycle
//   pc_write, ir_write                 PC / IF-ID enables
//   freeze_ex, freeze_mem              hold EX / MEM registers
//   bubblify_id, bubblify_mem          zero control of ID / MEM outputs
//   flush_if                           load IR with nop
//   incr_num_inst                      one instruction retires cleanly
//   perf_stall_cyc, perf_flush, perf_arb_wait
//                                      saturating counters, present only when
//                                      HAZARD_PERF_CNT_EN is defined
module hazard_ctrl_arb
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W         = REG_ADDR_W_DEF,
    parameter int unsigned DATA_FORWARDING    = 1,
    parameter int unsigned RF_SELF_FORWARDING = 1,
    parameter int unsigned TURNAROUND         = 1,
    parameter int unsigned PERF_W             = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  use_rs,
    input  logic                  use_rt,
    input  logic                  use_rs_at_id,
    input  logic                  reg_write_ex,
    input  logic                  reg_write_mem,
    input  logic                  reg_write_wb,
    input  logic [REG_ADDR_W-1:0] write_reg_ex,
    input  logic [REG_ADDR_W-1:0] write_reg_mem,
    input  logic [REG_ADDR_W-1:0] write_reg_wb,
    input  logic                  d_mem_read_ex,
    input  logic                  d_req_mem,
    input  logic                  jump_miss,
    input  logic                  cond_branch_miss,
    input  logic                  mem_ready,
    output logic                  i_mem_read,
    output logic                  d_mem_grant,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  freeze_ex,
    output logic                  freeze_mem,
    output logic                  bubblify_id,
    output logic                  bubblify_mem,
    output logic                  flush_if,
    output logic                  incr_num_inst
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     perf_stall_cyc,
    output logic [PERF_W-1:0]     perf_flush,
    output logic [PERF_W-1:0]     perf_arb_wait
`endif
);

    localparam logic FWD_EN     = (DATA_FORWARDING != 0);
    localparam logic RF_SELF_EN = (RF_SELF_FORWARDING != 0);

    arb_state_e arb_state;
    logic       miss;
    logic       miss_abort;
    logic       if_done;
    logic       d_done;
    logic       mem_stall;

    logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic raw_ex, raw_mem, raw_wb;
    logic load_use, nofwd_stall, id_use_stall, id_stall;

    logic pc_write_c, ir_write_c, freeze_ex_c, freeze_mem_c;
    logic bubblify_id_c, bubblify_mem_c, flush_if_c;

    assign miss       = jump_miss | cond_branch_miss;
    assign if_done    = (arb_state == ARB_IF) & mem_ready;
    assign d_done     = (arb_state == ARB_D) & mem_ready;
    assign miss_abort = (arb_state == ARB_IF) & !mem_ready & miss;
    assign mem_stall  = d_req_mem & !d_done;

    mem_port_arb #(
        .TURNAROUND(TURNAROUND)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_req_mem (d_req_mem),
        .fetch_want(1'b1),
        .abort     (miss_abort),
        .mem_ready (mem_ready),
        .state_o   (arb_state)
    );

    // Source-vs-destination matches per stage.
    assign rs_ex  = use_rs & (rs_id == write_reg_ex);
    assign rt_ex  = use_rt & (rt_id == write_reg_ex);
    assign rs_mem = use_rs & (rs_id == write_reg_mem);
    assign rt_mem = use_rt & (rt_id == write_reg_mem);
    assign rs_wb  = use_rs & (rs_id == write_reg_wb);
    assign rt_wb  = use_rt & (rt_id == write_reg_wb);

    assign raw_ex  = reg_write_ex  & (rs_ex  | rt_ex);
    assign raw_mem = reg_write_mem & (rs_mem | rt_mem);
    assign raw_wb  = !RF_SELF_EN & reg_write_wb & (rs_wb | rt_wb);

    assign load_use    = d_mem_read_ex & (rs_ex | rt_ex);
    assign nofwd_stall = !FWD_EN & (raw_ex | raw_mem | raw_wb);
    // Register jumps read rs in ID, ahead of the forwarding network.
    assign id_use_stall = use_rs_at_id &
                          ((reg_write_ex  & (rs_id == write_reg_ex)) |
                           (reg_write_mem & (rs_id == write_reg_mem)));
    assign id_stall = load_use | nofwd_stall | id_use_stall;

    always_comb begin
        pc_write_c     = 1'b1;
        ir_write_c     = 1'b1;
        freeze_ex_c    = 1'b0;
        freeze_mem_c   = 1'b0;
        bubblify_id_c  = 1'b0;
        bubblify_mem_c = 1'b0;
        flush_if_c     = 1'b0;
        if (mem_stall) begin
            pc_write_c     = 1'b0;
            ir_write_c     = 1'b0;
            freeze_ex_c    = 1'b1;
            freeze_mem_c   = 1'b1;
            bubblify_mem_c = 1'b1;
        end else if (id_stall) begin
            pc_write_c    = 1'b0;
            ir_write_c    = 1'b0;
            bubblify_id_c = 1'b1;
        end else begin
            if (jump_miss) begin
                flush_if_c = 1'b1;
            end
            if (cond_branch_miss) begin
                flush_if_c    = 1'b1;
                bubblify_id_c = 1'b1;
            end
            // An aborted fetch still lets the redirect through: the PC takes
            // the new target and the IR is loaded with a nop this cycle.
            if (!if_done && !miss_abort) begin
                pc_write_c     = 1'b0;
                ir_write_c     = 1'b0;
                freeze_ex_c    = 1'b1;
                freeze_mem_c   = 1'b1;
                bubblify_mem_c = 1'b1;
                flush_if_c     = 1'b0;
            end
        end
    end

    // Every output is forced low while reset is asserted.
    assign i_mem_read    = reset_n & (arb_state == ARB_IF);
    assign d_mem_grant   = reset_n & (arb_state == ARB_D);
    assign pc_write      = reset_n & pc_write_c;
    assign ir_write      = reset_n & ir_write_c;
    assign freeze_ex     = reset_n & freeze_ex_c;
    assign freeze_mem    = reset_n & freeze_mem_c;
    assign bubblify_id   = reset_n & bubblify_id_c;
    assign bubblify_mem  = reset_n & bubblify_mem_c;
    assign flush_if      = reset_n & flush_if_c;
    assign incr_num_inst = reset_n & pc_write_c & !bubblify_id_c
                         & !bubblify_mem_c & !flush_if_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cyc_q, flush_q, arb_wait_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cyc_q <= '0;
            flush_q     <= '0;
            arb_wait_q  <= '0;
        end else begin
            if (!pc_write_c && (stall_cyc_q != '1)) begin
                stall_cyc_q <= stall_cyc_q + 1'b1;
            end
            if (flush_if_c && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
            if (d_req_mem && (arb_state != ARB_D) && (arb_wait_q != '1)) begin
                arb_wait_q <= arb_wait_q + 1'b1;
            end
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_flush     = flush_q;
    assign perf_arb_wait  = arb_wait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_arb.sv
// Directed self-checking bench for hazard_ctrl_arb. Three instances share the
// stimulus: default configuration, no forwarding with TURNAROUND=2, and no
// forwarding with RF self-forwarding. Output vectors are packed as
// {i_mem_read, d_mem_grant, pc_write, ir_write, freeze_ex, freeze_mem,
//  bubblify_id, bubblify_mem, flush_if, incr_num_inst}.
module tb_hazard_ctrl_arb;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] rs_id, rt_id, write_reg_ex, write_reg_mem, write_reg_wb;
    logic       use_rs, use_rt, use_rs_at_id;
    logic       reg_write_ex, reg_write_mem, reg_write_wb;
    logic       d_mem_read_ex, d_req_mem, jump_miss, cond_branch_miss, mem_ready;

    logic [9:0] o1, o2, o3;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] p1_stall, p1_flush, p1_wait;
    logic [3:0] p2_stall, p2_flush, p2_wait;
    logic [3:0] p3_stall, p3_flush, p3_wait;
`endif

    always #5 clk = ~clk;

    hazard_ctrl_arb #(
        .REG_ADDR_W(2), .DATA_FORWARDING(1), .RF_SELF_FORWARDING(1),
        .TURNAROUND(1), .PERF_W(4)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs(use_rs), .use_rt(use_rt), .use_rs_at_id(use_rs_at_id),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .write_reg_ex(write_reg_ex), .write_reg_mem(write_reg_mem), .write_reg_wb(write_reg_wb),
        .d_mem_read_ex(d_mem_read_ex), .d_req_mem(d_req_mem), .jump_miss(jump_miss),
        .cond_branch_miss(cond_branch_miss), .mem_ready(mem_ready),
        .i_mem_read(o1[9]), .d_mem_grant(o1[8]), .pc_write(o1[7]), .ir_write(o1[6]),
        .freeze_ex(o1[5]), .freeze_mem(o1[4]), .bubblify_id(o1[3]), .bubblify_mem(o1[2]),
        .flush_if(o1[1]), .incr_num_inst(o1[0])
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cyc(p1_stall), .perf_flush(p1_flush), .perf_arb_wait(p1_wait)
`endif
    );

    hazard_ctrl_arb #(
        .REG_ADDR_W(2), .DATA_FORWARDING(0), .RF_SELF_FORWARDING(0),
        .TURNAROUND(2), .PERF_W(4)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs(use_rs), .use_rt(use_rt), .use_rs_at_id(use_rs_at_id),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .write_reg_ex(write_reg_ex), .write_reg_mem(write_reg_mem), .write_reg_wb(write_reg_wb),
        .d_mem_read_ex(d_mem_read_ex), .d_req_mem(d_req_mem), .jump_miss(jump_miss),
        .cond_branch_miss(cond_branch_miss), .mem_ready(mem_ready),
        .i_mem_read(o2[9]), .d_mem_grant(o2[8]), .pc_write(o2[7]), .ir_write(o2[6]),
        .freeze_ex(o2[5]), .freeze_mem(o2[4]), .bubblify_id(o2[3]), .bubblify_mem(o2[2]),
        .flush_if(o2[1]), .incr_num_inst(o2[0])
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cyc(p2_stall), .perf_flush(p2_flush), .perf_arb_wait(p2_wait)
`endif
    );

    hazard_ctrl_arb #(
        .REG_ADDR_W(2), .DATA_FORWARDING(0), .RF_SELF_FORWARDING(1),
        .TURNAROUND(1), .PERF_W(4)
    ) u_dut3 (
        .clk(clk), .reset_n(reset_n), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs(use_rs), .use_rt(use_rt), .use_rs_at_id(use_rs_at_id),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .write_reg_ex(write_reg_ex), .write_reg_mem(write_reg_mem), .write_reg_wb(write_reg_wb),
        .d_mem_read_ex(d_mem_read_ex), .d_req_mem(d_req_mem), .jump_miss(jump_miss),
        .cond_branch_miss(cond_branch_miss), .mem_ready(mem_ready),
        .i_mem_read(o3[9]), .d_mem_grant(o3[8]), .pc_write(o3[7]), .ir_write(o3[6]),
        .freeze_ex(o3[5]), .freeze_mem(o3[4]), .bubblify_id(o3[3]), .bubblify_mem(o3[2]),
        .flush_if(o3[1]), .incr_num_inst(o3[0])
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cyc(p3_stall), .perf_flush(p3_flush), .perf_arb_wait(p3_wait)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] v(input logic imr, input logic dg, input logic pc,
                                     input logic ir, input logic fex, input logic fmem,
                                     input logic bid, input logic bmem, input logic fl,
                                     input logic inc);
        return {imr, dg, pc, ir, fex, fmem, bid, bmem, fl, inc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_id = '0; rt_id = '0; write_reg_ex = '0; write_reg_mem = '0; write_reg_wb = '0;
        use_rs = 1'b0; use_rt = 1'b0; use_rs_at_id = 1'b0;
        reg_write_ex = 1'b0; reg_write_mem = 1'b0; reg_write_wb = 1'b0;
        d_mem_read_ex = 1'b0; d_req_mem = 1'b0; jump_miss = 1'b0;
        cond_branch_miss = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #1 reset_n = 1'b0;
        #1;
        check("rst_out1", {22'd0, o1}, 32'd0);
        check("rst_out2", {22'd0, o2}, 32'd0);
        #1 reset_n = 1'b1;
        d_req_mem = 1'b1;
        #1;
        check("idle_dreq", {22'd0, o1}, {22'd0, v(0,0,0,0,1,1,0,1,0,0)});

        // Reset in the middle of a data access.
        tick(); #2;
        check("d_grant", {22'd0, o1}, {22'd0, v(0,1,0,0,1,1,0,1,0,0)});
        reset_n = 1'b0;
        #1;
        check("rst_mid_d", {22'd0, o1}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("rst_perf_stall", {28'd0, p1_stall}, 32'd0);
        check("rst_perf_wait", {28'd0, p1_wait}, 32'd0);
`endif
        tick();
        reset_n = 1'b1;
        #2;
        check("rst_idle", {22'd0, o1}, {22'd0, v(0,0,0,0,1,1,0,1,0,0)});

        // Data priority and turnaround gap (u_dut2 has TURNAROUND=2).
        tick(); #2;
        check("d_prio", {30'd0, o2[9:8]}, 32'b01);
        tick(); #2;
        check("d_hold", {30'd0, o2[9:8]}, 32'b01);
        tick(); mem_ready = 1'b1; #2;
        check("d_done", {22'd0, o2}, {22'd0, v(0,1,0,0,1,1,0,1,0,0)});
        tick(); d_req_mem = 1'b0; mem_ready = 1'b0; #2;
        check("gap1", {30'd0, o2[9:8]}, 32'b00);
        tick(); #2;
        check("gap2", {30'd0, o2[9:8]}, 32'b00);
        tick(); #2;
        check("idle_after_gap", {30'd0, o2[9:8]}, 32'b00);
        check("fetch_t1", {31'd0, o1[9]}, 32'd1);
        tick(); #2;
        check("fetch_after_gap", {30'd0, o2[9:8]}, 32'b10);

        // Branch miss while the fetch is still outstanding.
        cond_branch_miss = 1'b1;
        #1;
        check("br_abort", {22'd0, o1}, {22'd0, v(1,0,1,1,0,0,1,0,1,0)});
        tick(); cond_branch_miss = 1'b0; #2;
        check("after_abort", {22'd0, o1}, {22'd0, v(0,0,0,0,1,1,0,1,0,0)});
        tick();
        tick();

        // Load-use hazard: LW r1 in EX, ADD r2,r1,r3 in ID.
        mem_ready = 1'b1;
        use_rs = 1'b1; rs_id = 2'd1; use_rt = 1'b1; rt_id = 2'd3;
        reg_write_ex = 1'b1; write_reg_ex = 2'd1; d_mem_read_ex = 1'b1;
        #2;
        check("load_use", {22'd0, o1}, {22'd0, v(1,0,0,0,0,0,1,0,0,0)});
        tick(); clear_inputs();
        tick();
        tick(); mem_ready = 1'b1; #2;
        check("after_load_use", {22'd0, o1}, {22'd0, v(1,0,1,1,0,0,0,0,0,1)});
        tick(); mem_ready = 1'b0;
        tick();
        tick(); jump_miss = 1'b1; mem_ready = 1'b1; #2;
        check("jump_flush", {22'd0, o1}, {22'd0, v(1,0,1,1,0,0,0,0,1,0)});

        // RAW against WB / MEM / register-jump source.
        tick(); clear_inputs();
        use_rt = 1'b1; rt_id = 2'd3; reg_write_wb = 1'b1; write_reg_wb = 2'd3;
        #2;
        check("raw_wb_nosf", {31'd0, o2[3]}, 32'd1);
        check("raw_wb_sf", {31'd0, o3[3]}, 32'd0);
        check("raw_wb_fwd", {31'd0, o1[3]}, 32'd0);
        tick(); reg_write_wb = 1'b0; reg_write_mem = 1'b1; write_reg_mem = 2'd3; #2;
        check("raw_mem_nofwd", {31'd0, o3[3]}, 32'd1);
        check("raw_mem_fwd", {31'd0, o1[3]}, 32'd0);
        tick(); clear_inputs();
        use_rs = 1'b1; rs_id = 2'd2; use_rs_at_id = 1'b1;
        reg_write_ex = 1'b1; write_reg_ex = 2'd2;
        #2;
        check("jr_raw_ex", {31'd0, o1[3]}, 32'd1);
        tick(); clear_inputs();

        // Fresh reset, then drive the performance counters.
        reset_n = 1'b0;
        #1;
        check("rst2_out", {22'd0, o1}, 32'd0);
        tick(); reset_n = 1'b1;
        tick(); d_req_mem = 1'b1;
        tick(); tick(); tick();
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_4", {28'd0, p1_stall}, 32'd4);
        check("perf_wait_3", {28'd0, p1_wait}, 32'd3);
`endif
        #1;
        check("no_preempt", {30'd0, o1[9:8]}, 32'b10);
        d_req_mem = 1'b0;
        for (int i = 0; i < 16; i++) tick();
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_sat", {28'd0, p1_stall}, 32'd15);
        check("perf_flush_0", {28'd0, p1_flush}, 32'd0);
`endif
        jump_miss = 1'b1;
        tick(); jump_miss = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        check("perf_flush_1", {28'd0, p1_flush}, 32'd1);
        check("perf_stall_hold", {28'd0, p1_stall}, 32'd15);
        check("perf_wait_hold", {28'd0, p1_wait}, 32'd3);
`endif
        #1;
        check("after_jump_abort", {30'd0, o1[9:8]}, 32'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
